// File: rtl/snac_pkg.sv
// Shared definitions for the SNAC pad reader.
//   state_t          : reader FSM states
//   PHASES_6B/_3B    : number of TH phases per frame for 6- and 3-button scans
//   D_*              : bit positions of the pad lines inside PAD_IN
//   last_phase()     : index of the final phase for a given scan mode
package snac_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PHASE,
    S_COMMIT
  } state_t;

  localparam int PHASES_6B = 8;
  localparam int PHASES_3B = 2;

  localparam int D_UP    = 0;
  localparam int D_DOWN  = 1;
  localparam int D_LEFT  = 2;
  localparam int D_RIGHT = 3;
  localparam int D_TL    = 4;
  localparam int D_TR    = 5;

  function automatic logic [2:0] last_phase(input logic j3);
    return j3 ? 3'(PHASES_3B - 1) : 3'(PHASES_6B - 1);
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the six raw pad lines.
//   clk : sampling clock
//   rst : asynchronous active-high reset, forces both stages to ones
//         (ones = idle, nothing pressed on the active-low lines)
//   d   : asynchronous pad lines
//   q   : synchronized pad lines
module pad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] d,
  output logic [5:0] q
);

  logic [5:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snac_pad_reader.sv
// SNAC game pad reader. Drives the TH select line through a sequence of
// phases, samples the pad lines at the end of each phase, and publishes the
// decoded buttons once per frame.
//   CLK, RESET       : clock, asynchronous active-high reset
//   CE               : clock enable; timers and FSM advance only when high
//   J3BUT            : force 3-button scan (latched when a frame starts)
//   PAD_IN[5:0]      : raw active-low pad lines D5..D0
//   PAD_TH           : select line to the pad
//   P_*              : decoded buttons, active-high
//   PRESENT, SIX_BTN : pad / 6-button pad seen in the last committed frame
//   VALID            : one-CLK pulse when the outputs above are updated
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | TH high for IDLE ticks so the pad resets its phase counter
// S_PHASE  | TH = ~phase[0], held SETTLE ticks, sampled on the last tick
// S_COMMIT | copy shadow samples to the outputs, pulse VALID
module snac_pad_reader #(
  parameter int SETTLE = 16,
  parameter int IDLE   = 1600
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       J3BUT,
  input  logic [5:0] PAD_IN,
  output logic       PAD_TH,
  output logic       P_UP,
  output logic       P_DOWN,
  output logic       P_LEFT,
  output logic       P_RIGHT,
  output logic       P_A,
  output logic       P_B,
  output logic       P_C,
  output logic       P_START,
  output logic       P_MODE,
  output logic       P_X,
  output logic       P_Y,
  output logic       P_Z,
  output logic       PRESENT,
  output logic       SIX_BTN,
  output logic       VALID
);

  import snac_pkg::*;

  localparam int CNT_MAX = (SETTLE > IDLE) ? SETTLE : IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] IDLE_TC   = CNT_W'(IDLE - 1);
  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       phase, phase_nx;
  logic             j3_lat, j3_nx;
  logic             sample, commit;
  logic [5:0]       pad_s;

  // Shadows hold inverted (active-high) samples of only the lines decoded.
  logic [5:0] sh0;  // phase 0: C,B,RIGHT,LEFT,DOWN,UP
  logic [3:0] sh1;  // phase 1: START,A,D3 low,D2 low
  logic [3:0] sh5;  // phase 5: D3..D0 low
  logic [3:0] sh6;  // phase 6: MODE,X,Y,Z

  logic pres, six;

  pad_sync u_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (PAD_IN),
    .q   (pad_s)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      phase  <= '0;
      j3_lat <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      phase  <= phase_nx;
      j3_lat <= j3_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    phase_nx = phase;
    j3_nx    = j3_lat;
    sample   = 1'b0;
    commit   = 1'b0;
    if (CE) begin
      unique case (state)
        S_IDLE: begin
          if (cnt == IDLE_TC) begin
            state_nx = S_PHASE;
            cnt_nx   = '0;
            phase_nx = '0;
            j3_nx    = J3BUT;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_PHASE: begin
          if (cnt == SETTLE_TC) begin
            sample = 1'b1;
            cnt_nx = '0;
            if (phase == last_phase(j3_lat)) begin
              state_nx = S_COMMIT;
              phase_nx = '0;
            end else begin
              phase_nx = phase + 3'd1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_COMMIT: begin
          commit   = 1'b1;
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          phase_nx = '0;
        end
      endcase
    end
  end

  assign PAD_TH = (state == S_PHASE) ? ~phase[0] : 1'b1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sh0 <= '0;
      sh1 <= '0;
      sh5 <= '0;
      sh6 <= '0;
    end else if (sample) begin
      case (phase)
        3'd0: sh0 <= ~pad_s;
        3'd1: sh1 <= ~{pad_s[D_TR], pad_s[D_TL], pad_s[D_RIGHT], pad_s[D_LEFT]};
        3'd5: sh5 <= ~pad_s[3:0];
        3'd6: sh6 <= ~pad_s[3:0];
        default: ;
      endcase
    end
  end

  // A pad pulls LEFT and RIGHT low together while TH is low; a 6-button pad
  // additionally pulls all four direction lines low on its third TH-low phase.
  assign pres = sh1[0] & sh1[1];
  assign six  = pres & ~j3_lat & (&sh5);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      VALID   <= 1'b0;
      PRESENT <= 1'b0;
      SIX_BTN <= 1'b0;
      P_UP    <= 1'b0;
      P_DOWN  <= 1'b0;
      P_LEFT  <= 1'b0;
      P_RIGHT <= 1'b0;
      P_A     <= 1'b0;
      P_B     <= 1'b0;
      P_C     <= 1'b0;
      P_START <= 1'b0;
      P_MODE  <= 1'b0;
      P_X     <= 1'b0;
      P_Y     <= 1'b0;
      P_Z     <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (commit) begin
        VALID   <= 1'b1;
        PRESENT <= pres;
        SIX_BTN <= six;
        P_UP    <= pres & sh0[D_UP];
        P_DOWN  <= pres & sh0[D_DOWN];
        P_LEFT  <= pres & sh0[D_LEFT];
        P_RIGHT <= pres & sh0[D_RIGHT];
        P_B     <= pres & sh0[D_TL];
        P_C     <= pres & sh0[D_TR];
        P_A     <= pres & sh1[2];
        P_START <= pres & sh1[3];
        P_Z     <= six & sh6[0];
        P_Y     <= six & sh6[1];
        P_X     <= six & sh6[2];
        P_MODE  <= six & sh6[3];
      end
    end
  end

endmodule

// File: doc/snac_pad_reader.md
SNAC_PAD_READER -- requirements
Module: snac_pad_reader

Interface
REQ-001 Parameter SETTLE, default 16, CE ticks each TH phase is held before sampling.
REQ-002 Parameter IDLE, default 1600, CE ticks TH is held high between frames, so the pad's internal phase counter resets.
REQ-003 CLK  in  1  sole clock; all logic is clocked on rising CLK.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 CE  in  1  clock enable; all timers and the FSM advance only on cycles with CE=1.
REQ-006 J3BUT  in  1  force 3-button mode (no 6-button probe).
REQ-007 PAD_IN  in  6  raw pad lines D5..D0 (TR,TL,RIGHT,LEFT,DOWN,UP), active-low, asynchronous to CLK.
REQ-008 PAD_TH  out  1  select line driven to the pad.
REQ-009 P_UP, P_DOWN, P_LEFT, P_RIGHT, P_A, P_B, P_C, P_START, P_MODE, P_X, P_Y, P_Z  out  1 each  decoded buttons, active-high.
REQ-010 PRESENT  out  1  pad detected in the last committed frame.
REQ-011 SIX_BTN  out  1  6-button pad detected in the last committed frame.
REQ-012 VALID  out  1  one-CLK pulse when outputs are updated.

Function
REQ-013 PAD_IN SHALL pass through a 2-flop synchronizer (clocked every CLK) before any use; the FSM samples only synchronized data.
REQ-014 FSM states: S_IDLE, S_PHASE, S_COMMIT.
REQ-015 S_IDLE: PAD_TH=1; after IDLE CE ticks, go to S_PHASE with phase index 0.
REQ-016 S_PHASE: PAD_TH = ~phase[0] (phase 0 TH=1, phase 1 TH=0, ...); hold for SETTLE CE ticks and sample on the last tick.
REQ-017 After sampling, phase increments; the last phase is 7, or 1 when J3BUT=1 (J3BUT is latched on S_IDLE exit).
REQ-018 After the last phase, go to S_COMMIT for one CE tick, then to S_IDLE.
REQ-019 Phase 0 sample: UP=~D0, DOWN=~D1, LEFT=~D2, RIGHT=~D3, B=~D4, C=~D5.
REQ-020 Phase 1 sample: pad present iff D2=0 and D3=0; A=~D4, START=~D5.
REQ-021 Phase 5 sample: 6-button iff D3..D0 = 0000.
REQ-022 Phase 6 sample: Z=~D0, Y=~D1, X=~D2, MODE=~D3.
REQ-023 Phases 2, 3, 4 and 7 SHALL be driven but not decoded.
REQ-024 Samples are held in shadow registers; visible outputs change only in S_COMMIT, all together, and VALID pulses on that same cycle.
REQ-025 At commit, if not present: all P_* = 0, PRESENT=0 and SIX_BTN=0.
REQ-026 At commit, if not 6-button or the latched J3BUT=1: P_X, P_Y, P_Z, P_MODE = 0 and SIX_BTN=0.
REQ-027 CE=0 SHALL freeze all state, timers and PAD_TH; outputs hold their values.
REQ-028 Latency: from S_IDLE exit to VALID = 8*SETTLE CE ticks + 1 (2*SETTLE + 1 with J3BUT).
REQ-029 The tick counter SHALL be wide enough for max(SETTLE, IDLE) with no wrap; a count reaching its terminal value SHALL reload, not roll over.

Reset
REQ-030 On RESET: state=S_IDLE, counters=0, phase=0, PAD_TH=1, all P_* = 0, PRESENT=0, SIX_BTN=0, VALID=0, shadows=0, synchronizer=all ones.
REQ-031 RESET asserted mid-frame SHALL discard partial samples; the first VALID after release comes only after a full IDLE period plus a full frame.

Structure
REQ-032 Shared package snac_pkg: the state enum, PHASES_6B=8, PHASES_3B=2, and the PAD_IN bit-index constants.
REQ-033 One sub-module, pad_sync: a 2-flop synchronizer, 6 bits wide, reset to ones.

Verification
REQ-034 CE=1 constant, SETTLE=4, IDLE=20, no pad (PAD_IN=6'h3F every phase) -> VALID pulse, PRESENT=0, all P_* = 0.
REQ-035 3-button model, A+UP pressed (TH=1: 6'h3E; TH=0: 6'h23) -> P_UP=1, P_A=1, others 0, PRESENT=1, SIX_BTN=0.
REQ-036 6-button model, X+START pressed (phase 5 D3..D0=0000, phase 6 D2=0) -> P_X=1, P_START=1, SIX_BTN=1; VALID at 33 CE ticks after S_IDLE exit.
REQ-037 Same 6-button stimulus with J3BUT=1 -> only 2 TH phases observed, P_X=0, SIX_BTN=0, VALID at 9 ticks.
REQ-038 RESET pulsed during phase 4 -> PAD_TH=1 immediately, outputs 0, next VALID no earlier than IDLE + 8*SETTLE + 1 ticks after release.
REQ-039 CE toggling 1-of-3 cycles -> PAD_TH phase widths equal 3*SETTLE CLKs and decoded results are identical to the CE=1 run.
